// File: rtl/gobang_referee_if.sv
// Move request handshake between the cursor/key logic and the referee.
interface gobang_referee_if;
    logic       move_valid;
    logic [3:0] move_x;
    logic [3:0] move_y;
    logic       move_ready;

    modport master (output move_valid, move_x, move_y, input move_ready);
    modport slave  (input move_valid, move_x, move_y, output move_ready);
endinterface

// File: rtl/gobang_referee.sv
// Gobang turn sequencer: validates moves, strobes board writes, then walks the
// four lines through the new stone one cell per cycle to find a win or a draw.
module gobang_referee #(
    parameter int BOARD_N = 10,
    parameter int WIN_LEN = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    gobang_referee_if.slave              mv,
    input  logic [BOARD_N*BOARD_N-1:0]   board_red,
    input  logic [BOARD_N*BOARD_N-1:0]   board_green,
    output logic                         place_en,
    output logic [6:0]                   place_idx,
    output logic                         place_red,
    output logic                         flag_player,
    output logic                         illegal_move,
    output logic                         busy,
    output logic                         game_over,
    output logic                         winner_red,
    output logic                         draw,
    output logic [6:0]                   move_count
);
    localparam int NC = BOARD_N * BOARD_N;
    localparam int IW = $clog2(NC);
    localparam int KW = $clog2(WIN_LEN) + 1;
    localparam logic signed [6:0] NS = 7'(BOARD_N);

    typedef enum logic [2:0] {IDLE, VALIDATE, PLACE, SETTLE, SCAN, TURN, OVER} state_t;
    state_t state, state_nx;

    logic [3:0]    cur_x, cur_y;
    logic [1:0]    dir;
    logic          phase_pos;
    logic [KW-1:0] k, run;

    logic          cur_in, cur_bad;
    logic [IW-1:0] cur_cell;

    assign cur_in   = (int'(cur_x) < BOARD_N) && (int'(cur_y) < BOARD_N);
    assign cur_cell = IW'(int'(cur_y) * BOARD_N + int'(cur_x));
    assign cur_bad  = !cur_in || board_red[cur_cell] || board_green[cur_cell];

    // Probe coordinates are signed so stepping off any edge is caught
    // instead of wrapping into the neighbouring row.
    logic signed [6:0] dxs, dys, ks, sk, px, py;
    logic              probe_on, mine, hit, last;
    logic [IW-1:0]     probe_cell;
    logic [KW-1:0]     run_end;

    always_comb begin
        dxs = 7'sd1;
        dys = 7'sd0;
        case (dir)
            2'd0:    begin dxs = 7'sd1; dys = 7'sd0;  end
            2'd1:    begin dxs = 7'sd0; dys = 7'sd1;  end
            2'd2:    begin dxs = 7'sd1; dys = 7'sd1;  end
            default: begin dxs = 7'sd1; dys = -7'sd1; end
        endcase
        ks = 7'(k);
        sk = phase_pos ? ks : -ks;
        px = $signed({3'b000, cur_x}) + sk * dxs;
        py = $signed({3'b000, cur_y}) + sk * dys;
    end

    assign probe_on   = (px >= 7'sd0) && (px < NS) && (py >= 7'sd0) && (py < NS);
    assign probe_cell = IW'(int'(py) * BOARD_N + int'(px));
    assign mine       = flag_player ? board_red[probe_cell] : board_green[probe_cell];
    assign hit        = probe_on && mine;
    assign last       = !hit || (k == KW'(WIN_LEN - 1));
    assign run_end    = run + KW'(hit);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (mv.move_valid) state_nx = VALIDATE;
            VALIDATE: state_nx = cur_bad ? IDLE : PLACE;
            PLACE:    state_nx = SETTLE;
            SETTLE:   state_nx = SCAN;
            SCAN: begin
                if (last && phase_pos) begin
                    if (run_end >= KW'(WIN_LEN)) state_nx = OVER;
                    else if (dir == 2'd3)        state_nx = TURN;
                end
            end
            TURN:     state_nx = (move_count == 7'(NC)) ? OVER : IDLE;
            OVER:     state_nx = OVER;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cur_x       <= '0;
            cur_y       <= '0;
            dir         <= '0;
            phase_pos   <= 1'b0;
            k           <= '0;
            run         <= '0;
            flag_player <= 1'b1;
            move_count  <= '0;
            winner_red  <= 1'b0;
            draw        <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (mv.move_valid) begin
                    cur_x <= mv.move_x;
                    cur_y <= mv.move_y;
                end
                PLACE:  move_count <= move_count + 7'd1;
                SETTLE: begin
                    dir       <= 2'd0;
                    phase_pos <= 1'b0;
                    k         <= KW'(1);
                    run       <= KW'(1);
                end
                SCAN: begin
                    if (!last) begin
                        k   <= k + KW'(1);
                        run <= run_end;
                    end else if (!phase_pos) begin
                        phase_pos <= 1'b1;
                        k         <= KW'(1);
                        run       <= run_end;
                    end else begin
                        if (run_end >= KW'(WIN_LEN)) winner_red <= flag_player;
                        dir       <= dir + 2'd1;
                        phase_pos <= 1'b0;
                        k         <= KW'(1);
                        run       <= KW'(1);
                    end
                end
                TURN: begin
                    if (move_count == 7'(NC)) draw <= 1'b1;
                    else                      flag_player <= !flag_player;
                end
                default: ;
            endcase
        end
    end

    assign mv.move_ready = (state == IDLE);
    assign place_en      = (state == PLACE);
    assign place_idx     = 7'(int'(cur_y) * BOARD_N + int'(cur_x));
    assign place_red     = flag_player;
    assign illegal_move  = (state == VALIDATE) && cur_bad;
    assign busy          = (state != IDLE) && (state != OVER);
    assign game_over     = (state == OVER);
endmodule

// File: tb/tb_gobang_referee.sv
// Directed bench: a 10x10 referee and a 4x4 referee, each with its own board
// storage model; expected placements are queued when a move is driven.
module tb_gobang_referee;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       sel = 1'b0;
    logic       mvv = 1'b0;
    logic [3:0] mvx = '0, mvy = '0;

    gobang_referee_if if10 ();
    gobang_referee_if if4 ();
    assign if10.move_valid = mvv & !sel;
    assign if10.move_x = mvx;
    assign if10.move_y = mvy;
    assign if4.move_valid = mvv & sel;
    assign if4.move_x = mvx;
    assign if4.move_y = mvy;

    logic [99:0] red10, grn10;
    logic [15:0] red4, grn4;
    logic       pe10, pr10, fp10, ill10, bz10, go10, wr10, dr10;
    logic       pe4, pr4, fp4, ill4, bz4, go4, wr4, dr4;
    logic [6:0] pi10, mc10, pi4, mc4;

    gobang_referee #(.BOARD_N(10), .WIN_LEN(5)) dut (
        .clk(clk), .rst(rst), .mv(if10.slave), .board_red(red10), .board_green(grn10),
        .place_en(pe10), .place_idx(pi10), .place_red(pr10), .flag_player(fp10),
        .illegal_move(ill10), .busy(bz10), .game_over(go10), .winner_red(wr10),
        .draw(dr10), .move_count(mc10));

    gobang_referee #(.BOARD_N(4), .WIN_LEN(5)) dut4 (
        .clk(clk), .rst(rst), .mv(if4.slave), .board_red(red4), .board_green(grn4),
        .place_en(pe4), .place_idx(pi4), .place_red(pr4), .flag_player(fp4),
        .illegal_move(ill4), .busy(bz4), .game_over(go4), .winner_red(wr4),
        .draw(dr4), .move_count(mc4));

    always_ff @(posedge clk) begin
        if (rst) begin
            red10 <= '0; grn10 <= '0; red4 <= '0; grn4 <= '0;
        end else begin
            if (pe10) begin
                if (pr10) red10[pi10] <= 1'b1;
                else      grn10[pi10] <= 1'b1;
            end
            if (pe4) begin
                if (pr4) red4[pi4[3:0]] <= 1'b1;
                else     grn4[pi4[3:0]] <= 1'b1;
            end
        end
    end

    logic       o_ready, o_pe, o_pred, o_ill, o_over, o_flag, o_busy, o_draw, o_win;
    logic [6:0] o_pidx, o_cnt;
    assign o_ready = sel ? if4.move_ready : if10.move_ready;
    assign o_pe    = sel ? pe4  : pe10;
    assign o_pred  = sel ? pr4  : pr10;
    assign o_pidx  = sel ? pi4  : pi10;
    assign o_ill   = sel ? ill4 : ill10;
    assign o_over  = sel ? go4  : go10;
    assign o_flag  = sel ? fp4  : fp10;
    assign o_busy  = sel ? bz4  : bz10;
    assign o_draw  = sel ? dr4  : dr10;
    assign o_win   = sel ? wr4  : wr10;
    assign o_cnt   = sel ? mc4  : mc10;

    typedef struct packed { logic legal; logic [6:0] idx; logic red; } exp_t;
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic exp_turn = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; mvv = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        exp_turn = 1'b1;
    endtask

    // Drives one move, checks the VALIDATE/PLACE outcome against the queued
    // expectation, then waits for IDLE or OVER (lat>0 checks edges from accept).
    task automatic do_move(input int x, input int y, input bit legal, input bit fin, input int lat);
        exp_t e, got;
        int   n;
        logic ill;
        e.legal = legal;
        e.idx   = 7'(y * (sel ? 4 : 10) + x);
        e.red   = exp_turn;
        sb.push_back(e);
        mvx = 4'(x); mvy = 4'(y); mvv = 1'b1;
        n = 0;
        while (!o_ready && n < 100) begin @(negedge clk); n++; end
        chk("accept_wait", 32'(n < 100), 32'd1);
        @(negedge clk);
        mvv = 1'b0;
        ill = o_ill;
        @(negedge clk);
        got = sb.pop_front();
        chk("legal", 32'(o_pe & !ill), 32'(got.legal));
        if (got.legal) begin
            chk("place_idx", 32'(o_pidx), 32'(got.idx));
            chk("place_red", 32'(o_pred), 32'(got.red));
            n = 1;
            while (!(o_ready || o_over) && n < 100) begin @(negedge clk); n++; end
            chk("game_over", 32'(o_over), 32'(fin));
            if (lat > 0) chk("latency", n, lat);
            if (!fin) exp_turn = !exp_turn;
        end else begin
            chk("illegal_pulse", 32'(ill), 32'd1);
            chk("back_idle", 32'(o_ready), 32'd1);
        end
    endtask

    initial begin
        logic any_pe;
        do_reset();
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_flag",  32'(o_flag),  32'd1);
        chk("rst_count", 32'(o_cnt),   32'd0);
        chk("rst_over",  32'(o_over),  32'd0);
        chk("rst_busy",  32'(o_busy),  32'd0);
        chk("rst_draw",  32'(o_draw),  32'd0);
        chk("rst_win",   32'(o_win),   32'd0);

        // first move and illegal requests
        do_move(3, 2, 1, 0, 12);
        chk("flag_after1", 32'(o_flag), 32'd0);
        chk("count_after1", 32'(o_cnt), 32'd1);
        do_move(3, 2, 0, 0, 0);
        do_move(10, 0, 0, 0, 0);
        do_move(0, 10, 0, 0, 0);
        chk("flag_after_ill", 32'(o_flag), 32'd0);
        chk("count_after_ill", 32'(o_cnt), 32'd1);

        // horizontal red win
        do_reset();
        for (int i = 0; i < 4; i++) begin
            do_move(i, 0, 1, 0, 0);
            do_move(i, 5, 1, 0, 0);
        end
        do_move(4, 0, 1, 1, 0);
        chk("row_winner", 32'(o_win), 32'd1);
        chk("row_draw", 32'(o_draw), 32'd0);
        chk("row_count", 32'(o_cnt), 32'd9);
        any_pe = 1'b0;
        mvx = 4'd7; mvy = 4'd7; mvv = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            any_pe = any_pe | o_pe;
            chk("over_not_ready", 32'(o_ready), 32'd0);
        end
        mvv = 1'b0;
        chk("over_no_place", 32'(any_pe), 32'd0);
        chk("over_count", 32'(o_cnt), 32'd9);

        // run split across a row boundary must not count
        do_reset();
        do_move(8, 0, 1, 0, 0); do_move(0, 9, 1, 0, 0);
        do_move(9, 0, 1, 0, 0); do_move(2, 9, 1, 0, 0);
        do_move(0, 1, 1, 0, 0); do_move(4, 9, 1, 0, 0);
        do_move(1, 1, 1, 0, 0); do_move(6, 9, 1, 0, 0);
        do_move(2, 1, 1, 0, 0);
        chk("wrap_over", 32'(o_over), 32'd0);
        chk("wrap_flag", 32'(o_flag), 32'd0);
        chk("wrap_count", 32'(o_cnt), 32'd9);

        // anti-diagonal green win
        do_reset();
        do_move(0, 9, 1, 0, 0); do_move(9, 0, 1, 0, 0);
        do_move(2, 9, 1, 0, 0); do_move(8, 1, 1, 0, 0);
        do_move(4, 9, 1, 0, 0); do_move(7, 2, 1, 0, 0);
        do_move(6, 9, 1, 0, 0); do_move(6, 3, 1, 0, 0);
        do_move(8, 9, 1, 0, 0); do_move(5, 4, 1, 1, 0);
        chk("anti_winner", 32'(o_win), 32'd0);
        chk("anti_draw", 32'(o_draw), 32'd0);
        chk("anti_count", 32'(o_cnt), 32'd10);

        // reset while scanning
        do_reset();
        mvx = 4'd5; mvy = 4'd5; mvv = 1'b1;
        @(negedge clk);
        mvv = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        chk("scan_busy", 32'(o_busy), 32'd1);
        chk("scan_count", 32'(o_cnt), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ready", 32'(o_ready), 32'd1);
        chk("midrst_flag", 32'(o_flag), 32'd1);
        chk("midrst_count", 32'(o_cnt), 32'd0);
        chk("midrst_pe", 32'(o_pe), 32'd0);
        chk("midrst_busy", 32'(o_busy), 32'd0);
        @(negedge clk);
        chk("midrst_pe2", 32'(o_pe), 32'd0);

        // 4x4 board fills without a five: draw
        sel = 1'b1;
        exp_turn = 1'b1;
        for (int i = 0; i < 16; i++) begin
            do_move(i % 4, i / 4, 1, (i == 15), 0);
            if (i == 14) chk("draw_not_yet", 32'(o_draw), 32'd0);
        end
        chk("draw_flag", 32'(o_draw), 32'd1);
        chk("draw_over", 32'(o_over), 32'd1);
        chk("draw_count", 32'(o_cnt), 32'd16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
